// File: rtl/fcvt_pkg.sv
// Shared types and helpers for the int->fp32 conversion sequencer.
// Optional unsigned support is enabled by defining FCVT_UNSIGNED_EN.
package fcvt_pkg;

  localparam int FP32_BIAS   = 127;
  localparam int FP32_MANT_W = 23;
  localparam int FP32_EXP_W  = 8;

  typedef struct packed {
    logic        sign;
    logic [31:0] mag;
    logic        id;
  } s1_t;

  function automatic logic [4:0] lead_one(input logic [31:0] v);
    logic [4:0] p;
    p = '0;
    for (int i = 0; i < 32; i++)
      if (v[i]) p = 5'(i);
    return p;
  endfunction

endpackage

// File: rtl/fcvt_round_pack.sv
// Normalise a 32-bit magnitude and round to fp32 (nearest, ties even).
// Purely combinational; sits between the S1 and S2 registers.
module fcvt_round_pack
  import fcvt_pkg::*;
(
  input  logic [31:0] mag,
  input  logic        sign,
  output logic [31:0] data,
  output logic        nx
);

  logic [4:0]             p;
  logic [31:0]            norm;
  logic [FP32_MANT_W-1:0] mant;
  logic                   guard;
  logic                   sticky;
  logic                   rnd;
  logic [FP32_MANT_W:0]   mant_r;
  logic [FP32_EXP_W-1:0]  expo;

  always_comb begin
    p      = lead_one(mag);
    norm   = mag << (5'd31 - p);
    mant   = norm[30:8];
    guard  = norm[7];
    sticky = |norm[6:0];
    rnd    = guard & (sticky | mant[0]);
    // a carry out of the mantissa leaves it zero and bumps the exponent
    mant_r = {1'b0, mant} + 24'(rnd);
    expo   = 8'(FP32_BIAS) + {3'b0, p} + {7'b0, mant_r[FP32_MANT_W]};
    nx     = guard | sticky;
    data   = {sign, expo, mant_r[FP32_MANT_W-1:0]};
    if (mag == '0) begin
      data = '0;
      nx   = 1'b0;
    end
  end

endmodule

// File: rtl/fcvt_arb.sv
// Two-port round-robin arbiter + 2-stage fcvt.s.w(u) pipeline.
// Define FCVT_UNSIGNED_EN to honour reqN_uns.
module fcvt_arb
  import fcvt_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_src,
  input  logic             req0_uns,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_src,
  input  logic             req1_uns,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [31:0]      rsp_data,
  output logic             rsp_nx,
  output logic             busy
);

  logic             lg;
  logic             stall;
  logic             gnt;
  logic             accept;
  logic             s1_valid;
  s1_t              s1_q;
  s1_t              s1_d;
  logic [TAG_W-1:0] s1_tag;
  logic [TAG_W-1:0] tag_sel;
  logic [31:0]      src_sel;
  logic [30:0]      neg31;
  logic [31:0]      rp_data;
  logic             rp_nx;

  assign stall  = rsp_valid & ~rsp_ready;
  // contention goes to the requester that did not win last
  assign gnt    = (req0_valid & req1_valid) ? ~lg : req1_valid;
  assign req0_ready = ~gnt & ~stall & ~resetn;
  assign req1_ready =  gnt & ~stall & ~resetn;
  assign accept = (req0_valid & req0_ready)
                | (req1_valid & req1_ready);

  assign src_sel = gnt ? req1_src : req0_src;
  assign tag_sel = gnt ? req1_tag : req0_tag;
  assign neg31   = 31'(0) - src_sel[30:0];

`ifdef FCVT_UNSIGNED_EN
  logic uns_sel;
  assign uns_sel = gnt ? req1_uns : req0_uns;

  always_comb begin
    s1_d.id = gnt;
    if (uns_sel) begin
      s1_d.sign = 1'b0;
      s1_d.mag  = src_sel;
    end else begin
      s1_d.sign = src_sel[31];
      s1_d.mag  = src_sel[31] ? (32'(0) - src_sel) : src_sel;
    end
  end
`else
  logic unused_uns;
  assign unused_uns = req0_uns ^ req1_uns;

  always_comb begin
    s1_d.id   = gnt;
    s1_d.sign = src_sel[31];
    s1_d.mag  = {1'b0, src_sel[31] ? neg31 : src_sel[30:0]};
    // INT_MIN has no 31-bit magnitude
    if (src_sel[31] && src_sel[30:0] == '0)
      s1_d.mag = 32'h8000_0000;
  end
`endif

  fcvt_round_pack u_round_pack (
    .mag  (s1_q.mag),
    .sign (s1_q.sign),
    .data (rp_data),
    .nx   (rp_nx)
  );

  always_ff @(posedge clk) begin
    if (resetn) begin
      lg        <= 1'b1;
      s1_valid  <= 1'b0;
      s1_q      <= '0;
      s1_tag    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_nx    <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_tag   <= '0;
    end else if (!stall) begin
      s1_valid  <= accept;
      rsp_valid <= s1_valid;
      if (accept) begin
        s1_q   <= s1_d;
        s1_tag <= tag_sel;
        lg     <= gnt;
      end
      if (s1_valid) begin
        rsp_data <= rp_data;
        rsp_nx   <= rp_nx;
        rsp_id   <= s1_q.id;
        rsp_tag  <= s1_tag;
      end
    end
  end

  assign busy = s1_valid | rsp_valid;

endmodule

// File: tb/tb_fcvt_arb.sv
// Scoreboard bench for fcvt_arb: directed vectors, queue-based checking.
// Unsigned expectations follow FCVT_UNSIGNED_EN.
module tb_fcvt_arb;

  logic        clk = 0;
  logic        resetn = 1;
  logic        req0_valid = 0, req1_valid = 0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_src = 0, req1_src = 0;
  logic        req0_uns = 0, req1_uns = 0;
  logic [3:0]  req0_tag = 0, req1_tag = 0;
  logic        rsp_valid, rsp_ready = 1;
  logic        rsp_id, rsp_nx, busy;
  logic [3:0]  rsp_tag;
  logic [31:0] rsp_data;

  int checks = 0;
  int failures = 0;
  int pops = 0;

  typedef struct {
    logic        id;
    logic [3:0]  tag;
    logic [31:0] data;
    logic        nx;
  } exp_t;
  exp_t sb[$];

  fcvt_arb #(.TAG_W(4)) dut (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_src(req0_src), .req0_uns(req0_uns), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_src(req1_src), .req1_uns(req1_uns), .req1_tag(req1_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
    .rsp_nx(rsp_nx), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // monitor: pop and compare on every response handshake
  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp actual=%h expected=none", rsp_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_nx", 32'(rsp_nx), 32'(e.nx));
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
      end
      pops++;
    end
  end

  task automatic push(input logic id, input logic [3:0] tag,
                      input logic [31:0] d, input logic nx);
    exp_t e;
    e.id = id; e.tag = tag; e.data = d; e.nx = nx;
    sb.push_back(e);
  endtask

  // called at posedge+1; returns at posedge+1 after the handshake edge
  task automatic send(input logic id, input logic [31:0] src,
                      input logic uns, input logic [3:0] tag,
                      input logic [31:0] ed, input logic enx);
    bit ok;
    ok = 0;
    if (id) begin
      req1_valid = 1; req1_src = src; req1_uns = uns; req1_tag = tag;
    end else begin
      req0_valid = 1; req0_src = src; req0_uns = uns; req0_tag = tag;
    end
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin
        ok = 1;
        break;
      end
    end
    if (ok) push(id, tag, ed, enx);
    else chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    req0_valid = 0;
    req1_valid = 0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk); #1;
      if (sb.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", 32'(sb.size()), 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    resetn = 1;
    rsp_ready = 0;
    req0_valid = 1;
    req1_valid = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_readies", {30'b0, req0_ready, req1_ready}, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_meta", {26'b0, rsp_nx, rsp_id, rsp_tag}, 0);
    @(posedge clk); #1;
    resetn = 0;
    req0_valid = 0;
    req1_valid = 0;
    rsp_ready = 1;
    sb.delete();
  endtask

  logic [31:0] s0 [3];
  logic [31:0] s1 [3];
  logic [31:0] e0 [3];
  logic [31:0] e1 [3];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int i0, i1, p0;
    logic g;
    logic [31:0] held;

    do_reset();

    // single conversion with latency check
    send(0, 32'd1, 0, 4'd1, 32'h3F80_0000, 0);
    @(negedge clk);
    chk("lat_n1_valid", 32'(rsp_valid), 0);
    @(negedge clk);
    chk("lat_n2_valid", 32'(rsp_valid), 1);
    @(posedge clk); #1;
    drain();

    send(1, 32'hFFFF_FFFF, 0, 4'd2, 32'hBF80_0000, 0);
    send(0, 32'h8000_0000, 0, 4'd3, 32'hCF00_0000, 0);
    send(1, 32'd16777217, 0, 4'd4, 32'h4B80_0000, 1);
    send(0, 32'd16777219, 0, 4'd5, 32'h4B80_0002, 1);
    send(1, 32'd0, 0, 4'd6, 32'h0000_0000, 0);
`ifdef FCVT_UNSIGNED_EN
    send(0, 32'hFFFF_FFFF, 1, 4'd7, 32'h4F80_0000, 1);
`else
    send(0, 32'hFFFF_FFFF, 1, 4'd7, 32'hBF80_0000, 0);
`endif
    drain();

    // contention: expect 0,1,0,1,0,1
    do_reset();
    s0 = '{32'd2, 32'd4, 32'd6};
    s1 = '{32'd3, 32'd5, 32'd7};
    e0 = '{32'h4000_0000, 32'h4080_0000, 32'h40C0_0000};
    e1 = '{32'h4040_0000, 32'h40A0_0000, 32'h40E0_0000};
    i0 = 0; i1 = 0;
    req0_src = s0[0]; req0_tag = 4'd0; req0_uns = 0;
    req1_src = s1[0]; req1_tag = 4'd8; req1_uns = 0;
    req0_valid = 1; req1_valid = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("grant", {30'b0, req0_ready, req1_ready},
          (k % 2 == 1) ? 32'd1 : 32'd2);
      g = req1_ready;
      if (g) push(1, 4'(8 + i1), e1[i1], 0);
      else   push(0, 4'(i0), e0[i0], 0);
      @(posedge clk); #1;
      if (g) i1++; else i0++;
      if (i0 < 3) begin req0_src = s0[i0]; req0_tag = 4'(i0); end
      else req0_valid = 0;
      if (i1 < 3) begin req1_src = s1[i1]; req1_tag = 4'(8 + i1); end
      else req1_valid = 0;
    end
    req0_valid = 0; req1_valid = 0;
    drain();

    // backpressure: two entries in flight, 3 stalled cycles
    rsp_ready = 0;
    send(0, 32'd10, 0, 4'd3, 32'h4120_0000, 0);
    send(1, 32'd100, 0, 4'd4, 32'h42C8_0000, 0);
    req0_valid = 1; req0_src = 32'd55; req0_tag = 4'd15;
    held = rsp_data;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_readies", {30'b0, req0_ready, req1_ready}, 0);
      chk("stall_valid", 32'(rsp_valid), 1);
      chk("stall_hold", rsp_data, held);
      chk("stall_busy", 32'(busy), 1);
    end
    @(posedge clk); #1;
    req0_valid = 0;
    rsp_ready = 1;
    p0 = pops;
    @(negedge clk);
    @(negedge clk); #1;
    chk("drain_consecutive", 32'(pops - p0), 2);
    repeat (4) @(negedge clk);
    #1;
    chk("no_dup", 32'(pops - p0), 2);
    @(posedge clk); #1;

    // reset mid-flight with S1 and S2 full
    rsp_ready = 0;
    send(0, 32'd1, 0, 4'd9, 32'h3F80_0000, 0);
    send(1, 32'd2, 0, 4'd10, 32'h4000_0000, 0);
    chk("full_busy", 32'(busy), 1);
    resetn = 1;
    @(posedge clk); #1;
    resetn = 0;
    sb.delete();
    rsp_ready = 1;
    req0_valid = 1; req0_src = 32'd7; req0_tag = 4'd5; req0_uns = 0;
    @(negedge clk);
    chk("post_rst_valid", 32'(rsp_valid), 0);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_ready", 32'(req0_ready), 1);
    if (req0_ready) push(0, 4'd5, 32'h40E0_0000, 0);
    @(posedge clk); #1;
    req0_valid = 0;
    drain();
    repeat (4) @(posedge clk);
    #1;
    chk("final_sb_empty", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fcvt_arb.md
# fcvt_arb

Two-port arbiter and pipeline sequencer for integer-to-single-precision conversion (fcvt.s.w / fcvt.s.wu). It shares one pipelined conversion datapath between two requesters, such as the integer issue slot and the FP issue slot. It accepts at most one operand per cycle through valid/ready handshakes and returns each IEEE-754 result with the requester id and tag. It sits between issue and FP writeback.

## Interface
- TAG_W, 4: width of the requester tag passed through unchanged.
- clk  in  1  clock; all state changes on its rising edge.
- resetn  in  1  reset, synchronous and active-high (asserted when 1).
- req0_valid / req1_valid  in  1  operand offered by requester 0 / 1.
- req0_ready / req1_ready  out  1  operand accepted this cycle when valid & ready.
- req0_src / req1_src  in  32  integer operand.
- req0_uns / req1_uns  in  1  1 = treat operand as unsigned (fcvt.s.wu).
- req0_tag / req1_tag  in  TAG_W  opaque tag.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result when valid & ready.
- rsp_id  out  1  requester that issued the result.
- rsp_tag  out  TAG_W  tag of the issuing request.
- rsp_data  out  32  IEEE-754 single-precision result.
- rsp_nx  out  1  inexact flag: result was rounded.
- busy  out  1  any pipeline stage holds a valid entry.

## Operation
- Pipeline stages:
  - S1 registers {sign, magnitude, id, tag}.
  - S2 registers {rsp_data, rsp_nx, id, tag} and drives rsp_*.
- Stall condition: stall = rsp_valid & !rsp_ready. While stalled:
  - S1 and S2 hold their contents.
  - Both reqN_ready outputs are 0.
- Arbitration is round-robin over a 1-bit last-grant pointer (lg):
  - Only one requester valid: that requester is granted.
  - Both valid: the requester != lg is granted.
  - reqN_ready = grant==N & !stall & !resetn. The grant is combinational from the valids; ready never depends on ready.
  - lg updates to the granted id only on a completed handshake.
- Magnitude computation:
  - Signed: sign = src[31]; magnitude = |src| as a 32-bit unsigned value. 0x80000000 gives magnitude 2^31.
  - Unsigned: sign = 0; magnitude = src.
- S2 conversion:
  - Find the leading-one position p (0..31). Exponent = 127 + p.
  - Shift so the leading one is dropped and 23 mantissa bits remain. Guard = next bit; sticky = OR of the rest.
  - Round to nearest, ties to even. Rounding carry out of the mantissa increments the exponent and clears the mantissa.
  - nx = guard | sticky.
- Zero operand → 0x00000000, nx = 0. Negative zero is never produced.
- Results return in acceptance order, with no reordering across requesters.

## Timing
- Latency: a handshake in cycle N gives rsp_valid in cycle N+2 when there is no stall.
- Throughput: one conversion per cycle.
- S1 advances into S2 whenever !stall. A bubble in S1 leaves S2 invalid after it drains.
- Reset values: rsp_valid=0, busy=0, req0_ready=0, req1_ready=0, lg=1 (so requester 0 wins the first contention). rsp_data, rsp_nx, rsp_id and rsp_tag are 0.
- Reset mid-operation: in-flight entries are discarded and no rsp_valid is emitted afterwards. The first handshake is possible in the cycle after resetn deasserts.
- Simultaneous rsp handshake and new request: S2 takes S1 and S1 takes the new request in the same edge, without a bubble.
- rsp_* hold stable while rsp_valid=1 and rsp_ready=0.

## Configuration
- FCVT_UNSIGNED_EN defined: reqN_uns is honoured as described above.
- FCVT_UNSIGNED_EN undefined:
  - reqN_uns is ignored and every operand is signed.
  - The magnitude path is 31 bits plus the INT_MIN special case.

## Structure
- Package fcvt_pkg holds:
  - FP32_BIAS = 127, FP32_MANT_W = 23, FP32_EXP_W = 8.
  - A typedef for the S1 entry struct.
  - A function giving the leading-one position.
- Sub-module fcvt_round_pack is combinational: magnitude, sign → {data, nx}, containing the leading-zero count, shift and round-to-nearest-even logic. It is instantiated once, between S1 and S2.
- The arbiter, handshake, stall and pipeline registers stay in fcvt_arb.

## Test plan
- Single conversions, with rsp_ready held 1:
  - req0 signed src=1 → rsp_data=0x3F800000, nx=0, rsp_id=0, rsp_valid two cycles after the handshake.
  - src=0xFFFFFFFF signed → 0xBF800000.
  - src=0x80000000 signed → 0xCF000000, nx=0.
- Rounding: src=16777217 → 0x4B800000, nx=1. src=16777219 → 0x4B800002, nx=1. src=0 → 0x00000000, nx=0.
- Unsigned (FCVT_UNSIGNED_EN): src=0xFFFFFFFF with uns=1 → 0x4F800000, nx=1. Without the macro, the same stimulus → 0xBF800000.
- Contention: both valid every cycle for 6 cycles → grants 0,1,0,1,0,1. Responses come back in that order with correct tags, one per cycle.
- Backpressure: rsp_ready=0 for 3 cycles with 2 entries in flight:
  - Both readies are 0 and rsp_* hold stable.
  - On release the results drain on consecutive cycles, with nothing lost or duplicated.
- Reset mid-flight: resetn=1 for one cycle with S1 and S2 full → rsp_valid=0 and busy=0 the next cycle. The stale results never appear.
